// File: rtl/bf_io_port_pkg.sv
// Shared types for the bfcpu io responder.
// Direction encoding and FSM state codes.
package bf_io_port_pkg;

   localparam logic DIR_READ  = 1'b0;
   localparam logic DIR_WRITE = 1'b1;

   typedef enum logic [1:0] {
      IOP_IDLE    = 2'd0,
      IOP_RD_WAIT = 2'd1,
      IOP_WR_WAIT = 2'd2,
      IOP_ACK     = 2'd3
   } iop_state_e;

   function automatic logic is_read(input logic dir);
      return dir == DIR_READ;
   endfunction

endpackage

// File: rtl/bf_sync_fifo.sv
// Synchronous FIFO, first-word-fall-through head.
// Push when full and pop when empty are ignored.
module bf_sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/bf_io_port.sv
// Responder for the bfcpu io_req/io_ack port: ',' reads
// from an RX FIFO, '.' writes into a TX FIFO.
module bf_io_port
   import bf_io_port_pkg::*;
#(
   parameter int         RX_DEPTH    = 16,
   parameter int         TX_DEPTH    = 16,
   parameter bit         RD_BLOCKING = 1'b1,
   parameter logic [7:0] EOF_VALUE   = 8'h00
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        io_req,
   input  logic                        io_dir,
   input  logic [7:0]                  io_wdata,
   output logic                        io_ack,
   output logic [7:0]                  io_rdata,
   input  logic                        in_valid,
   input  logic [7:0]                  in_data,
   output logic                        in_ready,
   output logic                        out_valid,
   output logic [7:0]                  out_data,
   input  logic                        out_ready,
   output logic [$clog2(RX_DEPTH):0]   rx_count,
   output logic [$clog2(TX_DEPTH):0]   tx_count
);

   iop_state_e state;
   logic [7:0] wdata_q;
   logic       rx_pop;
   logic       rx_full;
   logic       rx_empty;
   logic [7:0] rx_head;
   logic       tx_push;
   logic [7:0] tx_wdata;
   logic       tx_full;
   logic       tx_empty;

   assign in_ready  = ~rx_full;
   assign out_valid = ~tx_empty;

   bf_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid & in_ready),
      .push_data (in_data),
      .pop       (rx_pop),
      .head      (rx_head),
      .full      (rx_full),
      .empty     (rx_empty),
      .count     (rx_count)
   );

   bf_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx (
      .clk       (clk),
      .rst       (rst),
      .push      (tx_push),
      .push_data (tx_wdata),
      .pop       (out_valid & out_ready),
      .head      (out_data),
      .full      (tx_full),
      .empty     (tx_empty),
      .count     (tx_count)
   );

   // FIFO strobes mirror exactly the FSM transitions that ack.
   always_comb begin
      rx_pop   = 1'b0;
      tx_push  = 1'b0;
      tx_wdata = wdata_q;
      unique case (state)
         IOP_IDLE: begin
            if (io_req) begin
               if (is_read(io_dir)) begin
                  rx_pop = ~rx_empty;
               end else begin
                  tx_push  = ~tx_full;
                  tx_wdata = io_wdata;
               end
            end
         end
         IOP_RD_WAIT: rx_pop  = io_req & ~rx_empty;
         IOP_WR_WAIT: tx_push = io_req & ~tx_full;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IOP_IDLE;
         io_ack   <= 1'b0;
         io_rdata <= 8'h00;
         wdata_q  <= 8'h00;
      end else begin
         unique case (state)
            IOP_IDLE: begin
               if (io_req) begin
                  wdata_q <= io_wdata;
                  if (is_read(io_dir)) begin
                     if (!rx_empty) begin
                        io_rdata <= rx_head;
                        io_ack   <= 1'b1;
                        state    <= IOP_ACK;
                     end else if (RD_BLOCKING) begin
                        state <= IOP_RD_WAIT;
                     end else begin
                        io_rdata <= EOF_VALUE;
                        io_ack   <= 1'b1;
                        state    <= IOP_ACK;
                     end
                  end else if (!tx_full) begin
                     io_ack <= 1'b1;
                     state  <= IOP_ACK;
                  end else begin
                     state <= IOP_WR_WAIT;
                  end
               end
            end
            IOP_RD_WAIT: begin
               if (!io_req) begin
                  state <= IOP_IDLE;
               end else if (!rx_empty) begin
                  io_rdata <= rx_head;
                  io_ack   <= 1'b1;
                  state    <= IOP_ACK;
               end
            end
            IOP_WR_WAIT: begin
               if (!io_req) begin
                  state <= IOP_IDLE;
               end else if (!tx_full) begin
                  io_ack <= 1'b1;
                  state  <= IOP_ACK;
               end
            end
            IOP_ACK: begin
               if (!io_req) begin
                  io_ack <= 1'b0;
                  state  <= IOP_IDLE;
               end
            end
            default: state <= IOP_IDLE;
         endcase
      end
   end

endmodule
